hash_compare: RTL and testbench

- Registered 64-entry hash matcher for the NTLM cracker datapath.
- Compares one 128-bit candidate hash, produced by the hash core, against a packed table of 64 target hashes.
- Reports the index of the matching entry, or 64 when no entry matches.
- Sits between the hash-generation pipeline and the cracker control/result logic.

---
 rtl/hash_compare.sv | 62 ++++++
 tb/tb_hash_compare.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_compare.sv
// hash_compare: 128-bit candidate vs 64-entry target table -> lowest matching index, or 64 on miss.
// Latency 1 cycle from cmp_start; no backpressure, a new compare may start every cycle.
// Optional HASH_CMP_MASK_EN adds entry_en so individual table entries can be disabled.
module hash_compare #(
    parameter int NUM_HASHES = 64,
    parameter int HASH_W     = 128,
    parameter int MATCH_W    = 7
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [0:NUM_HASHES*HASH_W-1]     fucktonofhashes,
    input  logic [0:HASH_W-1]                outputhash,
    input  logic                             cmp_start,
`ifdef HASH_CMP_MASK_EN
    input  logic [0:NUM_HASHES-1]            entry_en,
`endif
    output logic [0:MATCH_W-1]               match,
    output logic                             match_valid,
    output logic                             match_found
);

    localparam logic [0:MATCH_W-1] NO_MATCH = MATCH_W'(NUM_HASHES);

    logic [0:NUM_HASHES-1] hit;
    logic [0:MATCH_W-1]    enc;

    // Entry i is the big-endian slice starting at bit i*HASH_W.
    always_comb begin
        for (int i = 0; i < NUM_HASHES; i++) begin
`ifdef HASH_CMP_MASK_EN
            hit[i] = entry_en[i] && (fucktonofhashes[i*HASH_W +: HASH_W] == outputhash);
`else
            hit[i] = (fucktonofhashes[i*HASH_W +: HASH_W] == outputhash);
`endif
        end
    end

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        enc = NO_MATCH;
        for (int i = NUM_HASHES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                enc = MATCH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            match       <= NO_MATCH;
            match_valid <= 1'b0;
            match_found <= 1'b0;
        end else begin
            match_valid <= cmp_start;
            if (cmp_start) begin
                match       <= enc;
                match_found <= (enc != NO_MATCH);
            end
        end
    end

endmodule

// File: tb/tb_hash_compare.sv
// Randomized + directed bench for hash_compare against a table-search reference model.
module tb_hash_compare;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [0:8191] fucktonofhashes;
    logic [0:127]  outputhash;
    logic          cmp_start;
    logic [0:63]   entry_en;
    logic [0:6]    match;
    logic          match_valid;
    logic          match_found;

    logic [127:0]  tbl [64];
    logic [127:0]  cand;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] exp_match;
    logic       exp_valid;
    logic       exp_found;
    logic       started = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        fucktonofhashes = '0;
        for (int i = 0; i < 64; i++) fucktonofhashes[i*128 +: 128] = tbl[i];
        outputhash = cand;
    end

    hash_compare dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .fucktonofhashes (fucktonofhashes),
        .outputhash      (outputhash),
        .cmp_start       (cmp_start),
`ifdef HASH_CMP_MASK_EN
        .entry_en        (entry_en),
`endif
        .match           (match),
        .match_valid     (match_valid),
        .match_found     (match_found)
    );

    // Reference: linear search for the first enabled entry equal to the candidate.
    function automatic logic [6:0] ref_search();
`ifdef HASH_CMP_MASK_EN
        for (int i = 0; i < 64; i++) if (entry_en[i] && tbl[i] == cand) return 7'(i);
`else
        for (int i = 0; i < 64; i++) if (tbl[i] == cand) return 7'(i);
`endif
        return 7'd64;
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        if (!n_rst) begin
            exp_match <= 7'd64;
            exp_valid <= 1'b0;
            exp_found <= 1'b0;
        end else begin
            exp_valid <= cmp_start;
            if (cmp_start) begin
                exp_match <= ref_search();
                exp_found <= (ref_search() < 7'd64);
            end
        end
    end

    task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_match", match, exp_match);
            chk("model_valid", 7'(match_valid), 7'(exp_valid));
            chk("model_found", 7'(match_found), 7'(exp_found));
        end
    end

    task automatic clear_tbl();
        for (int i = 0; i < 64; i++) tbl[i] = '0;
    endtask

    // One-cycle compare pulse; returns at the negedge where the result is visible.
    task automatic pulse(input logic [127:0] h);
        @(negedge clk);
        cand = h;
        cmp_start = 1'b1;
        @(negedge clk);
        cmp_start = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] H0   = 128'h66F3BFAF_B6FC6941_F189C0AA_F603E165;
    localparam logic [127:0] H3   = 128'hAE0079B3_EB9D0F6E_F69E136C_B064882C;
    localparam logic [127:0] HMIS = 128'h59DF803E_66C074E0_A2DB8ED4_122A4E9F;

    initial begin
        logic [127:0] pool [8];
        logic [6:0]   idx_list [3];
        logic [6:0]   first_exp;

        n_rst = 1'b0;
        cmp_start = 1'b1;
        entry_en = '1;
        clear_tbl();
        cand = H0;
        tbl[0] = H0;

        // Reset wins over cmp_start.
        repeat (2) @(negedge clk);
        chk("reset_match", match, 7'd64);
        chk("reset_valid", 7'(match_valid), 7'd0);
        chk("reset_found", 7'(match_found), 7'd0);
        n_rst = 1'b1;
        cmp_start = 1'b0;

        clear_tbl();
        tbl[0] = H0;
        pulse(H0);
        chk("hit0_match", match, 7'd0);
        chk("hit0_valid", 7'(match_valid), 7'd1);
        chk("hit0_found", 7'(match_found), 7'd1);
        @(negedge clk);
        chk("hold_valid", 7'(match_valid), 7'd0);
        chk("hold_match", match, 7'd0);

        idx_list[0] = 7'd1; idx_list[1] = 7'd39; idx_list[2] = 7'd63;
        for (int k = 0; k < 3; k++) begin
            clear_tbl();
            tbl[idx_list[k]] = H0 ^ {121'd0, idx_list[k]} ^ 128'h1234_0000;
            pulse(tbl[idx_list[k]]);
            chk("hit_idx", match, idx_list[k]);
        end

        clear_tbl();
        tbl[3] = H3;
        pulse(HMIS);
        chk("miss_match", match, 7'd64);
        chk("miss_found", 7'(match_found), 7'd0);
        chk("miss_valid", 7'(match_valid), 7'd1);

        clear_tbl();
        tbl[0] = H0;
        pulse(H0 ^ 128'h1);
        chk("onebit_match", match, 7'd64);

        // Duplicates and streaming.
        clear_tbl();
        tbl[5] = H3;
        tbl[20] = H3;
`ifdef HASH_CMP_MASK_EN
        entry_en[5] = 1'b0;
        first_exp = 7'd20;
`else
        first_exp = 7'd5;
`endif
        @(negedge clk);
        cand = H3; cmp_start = 1'b1;
        @(negedge clk);
        chk("dup1_match", match, first_exp);
        chk("dup1_valid", 7'(match_valid), 7'd1);
        cand = tbl[20];
        @(negedge clk);
        chk("dup2_match", match, first_exp);
        chk("dup2_valid", 7'(match_valid), 7'd1);
        cand = HMIS;
        @(negedge clk);
        chk("dup3_match", match, 7'd64);
        chk("dup3_valid", 7'(match_valid), 7'd1);
        cmp_start = 1'b0;
        entry_en = '1;

        // Randomized traffic from a small pool so hits and duplicates are common.
        for (int i = 0; i < 8; i++) pool[i] = rnd128();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 3) == 0)
                    tbl[i] = ($urandom_range(0, 2) == 0) ? rnd128() : pool[$urandom_range(0, 7)];
            end
            cand = ($urandom_range(0, 4) == 0) ? rnd128() : pool[$urandom_range(0, 7)];
            cmp_start = ($urandom_range(0, 3) != 0);
            n_rst = ($urandom_range(0, 49) != 0);
`ifdef HASH_CMP_MASK_EN
            entry_en = {$urandom, $urandom} | {$urandom, $urandom};
`endif
        end
        @(negedge clk);
        n_rst = 1'b1;
        cmp_start = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
